vga_timing_engine: RTL
======================

// Module: vga_timing_engine
// PURPOSE
//  Parametrised VGA raster generator; successor to the fixed-mode VGA controller used behind clk_div_vga.
//  Generates H/V sync, data-enable and pixel-request coordinates for any mode, with configurable sync
//  polarity and a pixel-fetch latency so a RAM or sprite pipeline can sit between pix_x/pix_y and pixel.
//  Runs in the pixel clock domain; drives the board VGA pins directly from registered outputs.
// PARAMETERS
//  COLOR_W  4    bits per colour channel
//  H_ACTIVE 640  visible pixels per line;  H_FP 16, H_SYNC 96, H_BP 48  horizontal porch/sync widths
//  V_ACTIVE 480  visible lines per frame;  V_FP 10, V_SYNC 2,  V_BP 33  vertical porch/sync widths
//  HS_POL   0    active level of hs (0 = active-low);  VS_POL 0  active level of vs
//  LAT      2    clocks from pix_x/pix_y presentation to pixel valid at input (0..7)
// PORTS
//  clk          in   1         pixel clock
//  rst          in   1         asynchronous reset, active-high
//  pixel        in   3*COLOR_W {B,G,R} (R in LSBs) for request issued LAT clocks earlier
//  pix_x        out  XW        requested column, XW=$clog2(H_TOTAL)
//  pix_y        out  YW        requested row, YW=$clog2(V_TOTAL)
//  pix_valid    out  1         request is inside active area
//  hs, vs       out  1         sync outputs, polarity per HS_POL/VS_POL
//  de           out  1         output rgb is visible
//  rgb          out  3*COLOR_W colour to DAC, {B,G,R}
//  line_start   out  1         1-clk pulse with first visible pixel of each line on rgb
//  frame_start  out  1         1-clk pulse with pixel (0,0) on rgb
// BEHAVIOUR
//  - H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800), V_TOTAL likewise (525). Count order: active, FP, sync, BP.
//  - h_cnt 0..H_TOTAL-1 increments every clk; at H_TOTAL-1 wraps to 0 and v_cnt increments;
//    at (H_TOTAL-1,V_TOTAL-1) both wrap to 0 in the same edge.
//  - pix_x=h_cnt, pix_y=v_cnt (combinational from counters); pix_valid=(h<H_ACTIVE)&&(v<V_ACTIVE)&&!rst.
//  - Request stage: hs_i active when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vs_i likewise on v.
//  - hs_i/vs_i/pix_valid/line/frame flags delayed LAT stages, then one output register stage:
//    hs/vs/de/line_start/frame_start lag the counters by LAT+1 clocks; rgb registered from pixel
//    on the same edge, so rgb aligns with de. Total request->pin latency LAT+1.
//  - LAT=0 legal: pixel is sampled in the same cycle pix_x/pix_y are presented.
//  - rgb = de_next ? pixel : 0; blanking always drives 0.
//  - Reset (async, any time incl. mid-line): counters=0, all delay stages cleared; outputs immediately
//    hs=~HS_POL, vs=~VS_POL, de=0, rgb=0, line_start=0, frame_start=0. After release, the first
//    edge increments h_cnt from 0 (request (0,0) is presented while rst=0 before that edge), so
//    frame_start first asserts LAT+1 clocks after release.
//  - Parameter checks (elaboration $error): any width 0, LAT>7.
// CONFIGURATION
//  VGA_BORDER_EN defined: during visible output, rgb is forced to all-ones on column 0, column
//   H_ACTIVE-1, row 0 and row V_ACTIVE-1 (1-px white frame), overriding pixel; timing unchanged.
//  VGA_BORDER_EN undefined: rgb follows pixel everywhere in the active area; no override logic built.
// STRUCTURE
//  - vga_pkg: timing constants for 640x480@60 and 800x600@60 (active/FP/sync/BP), colour packing
//    localparams (R/G/B slice positions), mode_t struct-equivalent defines.
//  - Sub-module vga_sync_pipe: LAT-deep, reset-clearable delay line for {hs,vs,de,line,frame,border}.
//  - Counters, sync decode and output register live in vga_timing_engine.
// TESTING
//  1 Reset release, defaults: hs low for 96 clks every 800, period 800; vs low for 2 lines every 525
//    lines; frame period exactly 420000 clks.
//  2 pixel driven as {pix_y[3:0],pix_x[7:0]} delayed LAT=2 by the bench: rgb==expected at every de,
//    rgb==0 whenever de=0; frame_start coincides with rgb for (0,0), first at clk 3 after release.
//  3 Wrap: at h=799,v=524 next clk pix_x=0,pix_y=0,pix_valid=1; at h=799,v=100 next pix_y=101.
//  4 HS_POL=1,VS_POL=1, 800x600 from vga_pkg (H_TOTAL 1056, V_TOTAL 628): hs high 128 clks per line.
//  5 Assert rst at h=300,v=200 for 5 clks: outputs go to inactive values the same cycle; after
//    release raster restarts at (0,0), next frame_start LAT+1 clks later, no runt line_start.
//  6 VGA_BORDER_EN, pixel=0: rgb=12'hFFF at x=0,x=639,y=0,y=479 in visible area, 0 elsewhere.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: standard mode timings, colour channel positions and the pipeline flag bundle.
// The flag bundle gains a border bit when VGA_BORDER_EN is defined.
package vga_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } vga_axis_t;

    localparam vga_axis_t VGA640_H = '{640, 16, 96, 48};
    localparam vga_axis_t VGA640_V = '{480, 10, 2, 33};
    localparam vga_axis_t VGA800_H = '{800, 40, 128, 88};
    localparam vga_axis_t VGA800_V = '{600, 1, 4, 23};

    // Channel index within {B,G,R}; slice is [idx*COLOR_W +: COLOR_W]
    localparam int unsigned CH_R = 0;
    localparam int unsigned CH_G = 1;
    localparam int unsigned CH_B = 2;

    function automatic int unsigned axis_total(vga_axis_t a);
        return a.active + a.fp + a.sync + a.bp;
    endfunction

    typedef struct packed {
`ifdef VGA_BORDER_EN
        logic border;
`endif
        logic hs;
        logic vs;
        logic de;
        logic line;
        logic frame;
    } vga_flags_t;

endpackage

// File: rtl/vga_sync_pipe.sv
// vga_sync_pipe: LAT-deep delay line for the request-stage raster flags.
// Reset clears every stage so no stale sync or strobe leaks out after reset.
module vga_sync_pipe
    import vga_pkg::*;
#(
    parameter int unsigned LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  vga_flags_t i_flags,
    output vga_flags_t o_flags
);

    generate
        if (LAT == 0) begin : g_bypass
            logic w_unused;
            assign w_unused = clk ^ rst;
            assign o_flags  = i_flags;
        end else begin : g_pipe
            vga_flags_t r_stage [LAT];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < LAT; i++) begin
                        r_stage[i] <= '0;
                    end
                end else begin
                    r_stage[0] <= i_flags;
                    for (int i = 1; i < LAT; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_flags = r_stage[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_engine.sv
// vga_timing_engine: parametrised VGA raster generator with pixel-fetch latency LAT.
// Define VGA_BORDER_EN to overlay a 1-pixel white frame on the visible area.
module vga_timing_engine
    import vga_pkg::*;
#(
    parameter int unsigned COLOR_W  = 4,
    parameter int unsigned H_ACTIVE = VGA640_H.active,
    parameter int unsigned H_FP     = VGA640_H.fp,
    parameter int unsigned H_SYNC   = VGA640_H.sync,
    parameter int unsigned H_BP     = VGA640_H.bp,
    parameter int unsigned V_ACTIVE = VGA640_V.active,
    parameter int unsigned V_FP     = VGA640_V.fp,
    parameter int unsigned V_SYNC   = VGA640_V.sync,
    parameter int unsigned V_BP     = VGA640_V.bp,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter int unsigned LAT      = 2,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned XW      = $clog2(H_TOTAL),
    localparam int unsigned YW      = $clog2(V_TOTAL),
    localparam int unsigned CW      = 3 * COLOR_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] pixel,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          pix_valid,
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic [CW-1:0] rgb,
    output logic          line_start,
    output logic          frame_start
);

    generate
        if (COLOR_W == 0 || H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 ||
            H_BP == 0 || V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 ||
            V_BP == 0) begin : g_bad_width
            $error("vga_timing_engine: zero-width parameter");
        end
        if (LAT > 7) begin : g_bad_lat
            $error("vga_timing_engine: LAT must be 0..7");
        end
    endgenerate

    localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] H_EDGE = XW'(H_ACTIVE - 1);
    localparam logic [XW-1:0] HS_BEG = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] V_EDGE = YW'(V_ACTIVE - 1);
    localparam logic [YW-1:0] VS_BEG = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END = YW'(V_ACTIVE + V_FP + V_SYNC);

    logic [XW-1:0] r_h_cnt;
    logic [YW-1:0] r_v_cnt;
    vga_flags_t    w_req;
    vga_flags_t    w_dly;
    logic [CW-1:0] w_rgb_next;
    logic          r_hs;
    logic          r_vs;
    logic          r_de;
    logic          r_line;
    logic          r_frame;
    logic [CW-1:0] r_rgb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + YW'(1);
        end else begin
            r_h_cnt <= r_h_cnt + XW'(1);
        end
    end

    assign pix_x     = r_h_cnt;
    assign pix_y     = r_v_cnt;
    assign pix_valid = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT) && !rst;

    always_comb begin
        w_req       = '0;
        w_req.hs    = (r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END);
        w_req.vs    = (r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END);
        w_req.de    = pix_valid;
        w_req.line  = pix_valid && (r_h_cnt == '0);
        w_req.frame = pix_valid && (r_h_cnt == '0) && (r_v_cnt == '0);
`ifdef VGA_BORDER_EN
        w_req.border = (r_h_cnt == '0) || (r_h_cnt == H_EDGE) ||
                       (r_v_cnt == '0) || (r_v_cnt == V_EDGE);
`endif
    end

    vga_sync_pipe #(
        .LAT(LAT)
    ) u_pipe (
        .clk    (clk),
        .rst    (rst),
        .i_flags(w_req),
        .o_flags(w_dly)
    );

    // Blanking always drives black so the DAC never sees stale fetch data
    always_comb begin
        w_rgb_next = '0;
        if (w_dly.de) begin
            w_rgb_next = pixel;
        end
`ifdef VGA_BORDER_EN
        if (w_dly.de && w_dly.border) begin
            w_rgb_next = '1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hs    <= ~HS_POL;
            r_vs    <= ~VS_POL;
            r_de    <= 1'b0;
            r_line  <= 1'b0;
            r_frame <= 1'b0;
            r_rgb   <= '0;
        end else begin
            r_hs    <= w_dly.hs ? HS_POL : ~HS_POL;
            r_vs    <= w_dly.vs ? VS_POL : ~VS_POL;
            r_de    <= w_dly.de;
            r_line  <= w_dly.line;
            r_frame <= w_dly.frame;
            r_rgb   <= w_rgb_next;
        end
    end

    assign hs          = r_hs;
    assign vs          = r_vs;
    assign de          = r_de;
    assign line_start  = r_line;
    assign frame_start = r_frame;
    assign rgb         = r_rgb;

endmodule
